// File: rtl/mc_pkg.sv
// mc_pkg -- shared definitions for the multi-cycle sequencer slice.
//   state_e           : sequencer states, fetch through write-back
//   PH_IF..PH_WB      : bit positions inside the one-hot phase vector
//   RESET_PC_DEFAULT  : address of the first fetch after reset
package mc_pkg;

  typedef enum logic [2:0] {
    IF_REQ   = 3'd0,
    IF_WAIT  = 3'd1,
    ID       = 3'd2,
    EXE      = 3'd3,
    MEM_REQ  = 3'd4,
    MEM_WAIT = 3'd5,
    WB       = 3'd6
  } state_e;

  localparam int PH_IF  = 0;
  localparam int PH_ID  = 1;
  localparam int PH_EXE = 2;
  localparam int PH_MEM = 3;
  localparam int PH_WB  = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

endpackage

// File: rtl/mc_mem_hs.sv
// mc_mem_hs -- tracks one req/addr_ok/data_ok memory transaction.
// Ports:
//   clk, reset   : clock and asynchronous active-high reset
//   req_i        : request currently presented to the memory
//   addr_ok_i    : memory accepted the address this cycle
//   data_ok_i    : memory returns data this cycle
//   accept_o     : request accepted this cycle
//   done_o       : transaction completes this cycle (same-cycle or later)
// A data_ok that arrives while no transaction is outstanding is ignored.
module mc_mem_hs (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic addr_ok_i,
  input  logic data_ok_i,
  output logic accept_o,
  output logic done_o
);

  logic pending_q;

  assign accept_o = req_i & addr_ok_i;
  assign done_o   = (accept_o | pending_q) & data_ok_i;

  // Remember an accepted address whose data has not yet come back;
  // reset drops any outstanding transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
    end else if (accept_o && !data_ok_i) begin
      pending_q <= 1'b1;
    end else if (pending_q && data_ok_i) begin
      pending_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl -- multi-cycle instruction sequencer IF/ID/EXE/MEM/WB.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   inst_req/inst_addr/inst_addr_ok/inst_data_ok/inst_rdata : fetch port
//   data_req/data_wr/data_addr_ok/data_data_ok/data_rdata   : data port
//   dec_is_load/dec_is_store/dec_rf_we : class of the held instruction
//   next_pc                         : successor PC, taken in WB
//   ir, mem_rdata, pc               : latched instruction, load data, PC
//   phase                           : one-hot IF/ID/EXE/MEM/WB
//   rf_we, retire, retire_cnt       : write-back strobe, retire pulse, count
// Configuration macro MC_SEQ_SKIP_MEM_EN: when defined, instructions that
// neither load nor store go from EXE straight to WB.
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_rf_we,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [31:0]       ir,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        phase,
  output logic              rf_we,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       memRdata_q;
  logic [CNT_W-1:0]  retireCnt_q;

  logic isMem;
  logic instAccept, instDone;
  logic dataAccept, dataDone;

  assign isMem = dec_is_load | dec_is_store;

  // The fetch request is masked by reset itself because the state register
  // resets to IF_REQ, which would otherwise raise inst_req during reset.
  assign inst_req  = (state_q == IF_REQ) & ~reset;
  assign inst_addr = pc_q;
  assign data_req  = (state_q == MEM_REQ) & isMem;
  assign data_wr   = data_req & dec_is_store;

  assign ir         = ir_q;
  assign mem_rdata  = memRdata_q;
  assign pc         = pc_q;
  assign retire_cnt = retireCnt_q;

  mc_mem_hs u_inst_hs (
    .clk       (clk),
    .reset     (reset),
    .req_i     (inst_req),
    .addr_ok_i (inst_addr_ok),
    .data_ok_i (inst_data_ok),
    .accept_o  (instAccept),
    .done_o    (instDone)
  );

  mc_mem_hs u_data_hs (
    .clk       (clk),
    .reset     (reset),
    .req_i     (data_req),
    .addr_ok_i (data_addr_ok),
    .data_ok_i (data_data_ok),
    .accept_o  (dataAccept),
    .done_o    (dataDone)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IF_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and phase/strobe decode. A done in the request state means
  // address and data were accepted together, so the wait state is skipped.
  always_comb begin
    state_d = state_q;
    phase   = '0;
    rf_we   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IF_REQ: begin
        phase[PH_IF] = 1'b1;
        if (instDone)        state_d = ID;
        else if (instAccept) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        phase[PH_IF] = 1'b1;
        if (instDone) state_d = ID;
      end
      ID: begin
        phase[PH_ID] = 1'b1;
        state_d      = EXE;
      end
      EXE: begin
        phase[PH_EXE] = 1'b1;
`ifdef MC_SEQ_SKIP_MEM_EN
        state_d = isMem ? MEM_REQ : WB;
`else
        state_d = MEM_REQ;
`endif
      end
      MEM_REQ: begin
        phase[PH_MEM] = 1'b1;
        if (!isMem || dataDone) state_d = WB;
        else if (dataAccept)    state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        phase[PH_MEM] = 1'b1;
        if (dataDone) state_d = WB;
      end
      WB: begin
        phase[PH_WB] = 1'b1;
        rf_we        = dec_rf_we;
        retire       = 1'b1;
        state_d      = IF_REQ;
      end
      default: begin
        phase[PH_IF] = 1'b1;
        state_d      = IF_REQ;
      end
    endcase
  end

  // Datapath latches: instruction on fetch completion, load data on data
  // completion, PC and retire count once per instruction in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      memRdata_q  <= '0;
      retireCnt_q <= '0;
    end else begin
      if (instDone) begin
        ir_q <= inst_rdata;
      end
      if (dataDone && dec_is_load) begin
        memRdata_q <= data_rdata;
      end
      if (state_q == WB) begin
        pc_q        <= next_pc;
        retireCnt_q <= retireCnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl -- self-checking bench for mc_seq_ctrl: a per-cycle vector
// table (load with wait states, then zero-wait store) followed by hand
// sequences for asynchronous reset, ALU retire timing and counter wrap.
module tb_mc_seq_ctrl;

  localparam logic [31:0] PC0   = 32'h1c000000;
  localparam logic [31:0] PC1   = 32'h1c000100;
  localparam logic [31:0] PC2   = 32'h1c000200;
  localparam logic [31:0] INSTA = 32'h0000a083;
  localparam logic [31:0] INSTB = 32'h00b02023;
  localparam logic [31:0] DEAD  = 32'hdeadbeef;
  localparam logic [31:0] OTHER = 32'h12345678;
  localparam logic [4:0]  P_IF  = 5'b00001;
  localparam logic [4:0]  P_ID  = 5'b00010;
  localparam logic [4:0]  P_EX  = 5'b00100;
  localparam logic [4:0]  P_MEM = 5'b01000;
  localparam logic [4:0]  P_WB  = 5'b10000;
`ifdef MC_SEQ_SKIP_MEM_EN
  localparam int ALU_CYC = 4;
`else
  localparam int ALU_CYC = 5;
`endif
  localparam int NROWS = 20;

  typedef struct {
    logic        iaok, idok, daok, ddok, ld, st, rfw;
    logic [31:0] irdata, drdata, npc;
    logic [4:0]  ph;
    logic        ireq, dreq, dwr, rfwe, ret;
    logic [31:0] addr, ir, mrd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0, dec_rf_we = 1'b0;
  logic [31:0] next_pc = '0;

  logic        inst_req, data_req, data_wr, rf_we, retire;
  logic [31:0] inst_addr, ir, mem_rdata, pc, retire_cnt;
  logic [4:0]  phase;

  logic        w_inst_req, w_data_req, w_data_wr, w_rf_we, w_retire;
  logic [31:0] w_inst_addr, w_ir, w_mem_rdata, w_pc;
  logic [4:0]  w_phase;
  logic [3:0]  w_retire_cnt;

  int vectors = 0;
  int miscompares = 0;
  vec_t vecs [NROWS];

  mc_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rf_we(dec_rf_we),
    .next_pc(next_pc), .ir(ir), .mem_rdata(mem_rdata), .pc(pc),
    .phase(phase), .rf_we(rf_we), .retire(retire), .retire_cnt(retire_cnt)
  );

  mc_seq_ctrl #(.CNT_W(4)) dutW (
    .clk(clk), .reset(reset),
    .inst_req(w_inst_req), .inst_addr(w_inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(w_data_req), .data_wr(w_data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_rf_we(dec_rf_we),
    .next_pc(next_pc), .ir(w_ir), .mem_rdata(w_mem_rdata), .pc(w_pc),
    .phase(w_phase), .rf_we(w_rf_we), .retire(w_retire), .retire_cnt(w_retire_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    inst_addr_ok = v.iaok;
    inst_data_ok = v.idok;
    data_addr_ok = v.daok;
    data_data_ok = v.ddok;
    dec_is_load  = v.ld;
    dec_is_store = v.st;
    dec_rf_we    = v.rfw;
    inst_rdata   = v.irdata;
    data_rdata   = v.drdata;
    next_pc      = v.npc;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " phase"}, phase, P_IF);
    checkOutput({tag, " inst_req"}, inst_req, 0);
    checkOutput({tag, " data_req"}, data_req, 0);
    checkOutput({tag, " rf_we"}, rf_we, 0);
    checkOutput({tag, " retire"}, retire, 0);
    checkOutput({tag, " inst_addr"}, inst_addr, PC0);
    checkOutput({tag, " ir"}, ir, 0);
    checkOutput({tag, " mem_rdata"}, mem_rdata, 0);
    checkOutput({tag, " retire_cnt"}, retire_cnt, 0);
  endtask

  initial begin
    logic [4:0] phTab [NROWS];
    int retireAt [3];
    int retTot;
    int cyc;
    logic dreqSeen, oneHotBad, rfweBad;

    // Load: fetch addr_ok after 2 waits, data 3 cycles later, spurious
    // data_ok in ID, data_ok 4 cycles after data addr_ok. Then a zero-wait
    // store with dec_rf_we=0.
    phTab = '{P_IF, P_IF, P_IF, P_IF, P_IF, P_IF, P_ID, P_EX, P_MEM, P_MEM,
              P_MEM, P_MEM, P_MEM, P_WB, P_IF, P_ID, P_EX, P_MEM, P_WB, P_IF};
    for (int i = 0; i < NROWS; i++) begin
      vecs[i].iaok   = (i == 2) || (i == 14);
      vecs[i].idok   = (i == 5) || (i == 14);
      vecs[i].daok   = (i == 8) || (i == 17);
      vecs[i].ddok   = (i == 6) || (i == 12) || (i == 17);
      vecs[i].ld     = (i < 14);
      vecs[i].st     = (i >= 14);
      vecs[i].rfw    = (i < 14);
      vecs[i].irdata = (i < 14) ? INSTA : INSTB;
      vecs[i].drdata = (i < 14) ? DEAD : OTHER;
      vecs[i].npc    = (i < 14) ? PC1 : PC2;
      vecs[i].ph     = phTab[i];
      vecs[i].ireq   = (i <= 2) || (i == 14) || (i == 19);
      vecs[i].dreq   = (i == 8) || (i == 17);
      vecs[i].dwr    = (i == 17);
      vecs[i].rfwe   = (i == 13);
      vecs[i].ret    = (i == 13) || (i == 18);
      vecs[i].addr   = (i < 14) ? PC0 : ((i < 19) ? PC1 : PC2);
      vecs[i].ir     = (i < 6) ? 32'h0 : ((i < 15) ? INSTA : INSTB);
      vecs[i].mrd    = (i < 13) ? 32'h0 : DEAD;
    end

    // Reset values while reset is held.
    tick();
    checkResetValues("reset_hold");
    tick();
    reset = 1'b0;

    for (int i = 0; i < NROWS; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d phase", i), phase, vecs[i].ph);
      checkOutput($sformatf("row%0d inst_req", i), inst_req, vecs[i].ireq);
      checkOutput($sformatf("row%0d data_req", i), data_req, vecs[i].dreq);
      checkOutput($sformatf("row%0d data_wr", i), data_wr, vecs[i].dwr);
      checkOutput($sformatf("row%0d rf_we", i), rf_we, vecs[i].rfwe);
      checkOutput($sformatf("row%0d retire", i), retire, vecs[i].ret);
      checkOutput($sformatf("row%0d inst_addr", i), inst_addr, vecs[i].addr);
      checkOutput($sformatf("row%0d ir", i), ir, vecs[i].ir);
      checkOutput($sformatf("row%0d mem_rdata", i), mem_rdata, vecs[i].mrd);
      tick();
    end
    checkOutput("table retire_cnt", retire_cnt, 2);

    // Reset asserted mid-cycle while in IF_WAIT.
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    tick();
    inst_addr_ok = 1'b0;
    checkOutput("ifwait phase", phase, P_IF);
    checkOutput("ifwait inst_req", inst_req, 0);
    reset = 1'b1;
    #1;
    checkResetValues("reset_ifwait");
    tick();
    reset = 1'b0;
    #1;
    checkOutput("release inst_req", inst_req, 1);

    // Load to MEM_WAIT, then reset mid-cycle.
    dec_is_load = 1'b1; dec_is_store = 1'b0; dec_rf_we = 1'b1;
    inst_rdata = INSTA;
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    tick();
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    checkOutput("memwait phase", phase, P_MEM);
    checkOutput("memwait data_req", data_req, 0);
    checkOutput("memwait ir", ir, INSTA);
    reset = 1'b1;
    #1;
    checkResetValues("reset_memwait");
    checkOutput("reset_memwait data_wr", data_wr, 0);
    tick();
    reset = 1'b0;

    // Stale data_ok/inst_data_ok after release must not move the sequencer.
    data_data_ok = 1'b1;
    inst_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    inst_data_ok = 1'b0;
    checkOutput("abandon phase", phase, P_IF);
    checkOutput("abandon inst_req", inst_req, 1);
    checkOutput("abandon inst_addr", inst_addr, PC0);
    checkOutput("abandon ir", ir, 0);

    // Three ALU instructions with zero-wait memory, counted from release.
    reset = 1'b1;
    tick();
    tick();
    inst_addr_ok = 1'b1; inst_data_ok = 1'b1;
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_rf_we = 1'b1;
    next_pc = PC0 + 32'd4;
    reset = 1'b0;
    retTot = 0;
    dreqSeen = 1'b0; oneHotBad = 1'b0; rfweBad = 1'b0;
    retireAt = '{0, 0, 0};
    for (int c = 1; c <= 3 * ALU_CYC; c++) begin
      #1;
      if (data_req) dreqSeen = 1'b1;
      if (!$onehot(phase)) oneHotBad = 1'b1;
      if (rf_we !== retire) rfweBad = 1'b1;
      if (retire) begin
        if (retTot < 3) retireAt[retTot] = c;
        retTot++;
      end
      tick();
    end
    checkOutput("alu retire#1 cycle", retireAt[0], ALU_CYC);
    checkOutput("alu retire#2 cycle", retireAt[1], 2 * ALU_CYC);
    checkOutput("alu retire#3 cycle", retireAt[2], 3 * ALU_CYC);
    checkOutput("alu retire pulses", retTot, 3);
    checkOutput("alu retire_cnt", retire_cnt, 3);
    checkOutput("alu data_req seen", dreqSeen, 0);
    checkOutput("alu phase onehot", oneHotBad, 0);
    checkOutput("alu rf_we vs WB", rfweBad, 0);
    checkOutput("alu next fetch addr", inst_addr, PC0 + 32'd4);

    // Continue to 17 retirements for counter wrap on the 4-bit instance.
    cyc = 0;
    while (retTot < 17 && cyc < 500) begin
      #1;
      if (retire) retTot++;
      tick();
      cyc++;
    end
    checkOutput("wrap retirements", retTot, 17);
    checkOutput("wrap retire_cnt 32b", retire_cnt, 17);
    checkOutput("wrap retire_cnt 4b", {28'h0, w_retire_cnt}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
MC_SEQ_CTRL -- requirements
Module: mc_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and memory address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h1c000000: first fetch address.
REQ-003 SHALL have parameter CNT_W, default 32: retire counter width.
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports inst_req (output, 1), inst_addr (output, ADDR_W), inst_addr_ok (input, 1), inst_data_ok (input, 1) and inst_rdata (input, 32): instruction memory handshake.
REQ-007 SHALL have ports data_req (output, 1), data_wr (output, 1), data_addr_ok (input, 1), data_data_ok (input, 1) and data_rdata (input, 32): data memory handshake.
REQ-008 SHALL have ports dec_is_load (input, 1), dec_is_store (input, 1) and dec_rf_we (input, 1): decoder class of the held instruction.
REQ-009 SHALL have port next_pc, input, ADDR_W: branch-resolved successor PC.
REQ-010 SHALL have ports ir (output, 32), mem_rdata (output, 32) and pc (output, ADDR_W): latched instruction, latched load data and current PC.
REQ-011 SHALL have ports phase (output, 5, one-hot IF/ID/EXE/MEM/WB), rf_we (output, 1), retire (output, 1) and retire_cnt (output, CNT_W).

Function
REQ-012 SHALL use states IF_REQ, IF_WAIT, ID, EXE, MEM_REQ, MEM_WAIT, WB.
REQ-013 In IF_REQ: inst_req=1 and inst_addr=pc, held stable until inst_addr_ok; on addr_ok go to IF_WAIT.
REQ-014 If inst_data_ok arrives in the same cycle as inst_addr_ok: latch inst_rdata into ir and go directly to ID.
REQ-015 In IF_WAIT: on inst_data_ok latch ir and go to ID; otherwise stay, with unbounded wait.
REQ-016 ID and EXE: one cycle each, unconditional.
REQ-017 MEM_REQ: data_req=1 and data_wr=dec_is_store, held until data_addr_ok; then MEM_WAIT, or straight to WB if data_data_ok arrives in the same cycle.
REQ-018 MEM_WAIT: on data_data_ok go to WB; latch data_rdata into mem_rdata only when dec_is_load.
REQ-019 WB: one cycle; rf_we=dec_rf_we; retire=1; pc<=next_pc; retire_cnt increments with modulo 2^CNT_W wrap; next state IF_REQ.
REQ-020 inst_data_ok and data_data_ok SHALL be ignored in every state that does not await them.
REQ-021 phase SHALL be one-hot at all times: IF for IF_REQ/IF_WAIT, MEM for MEM_REQ/MEM_WAIT.
REQ-022 rf_we and retire SHALL be 0 outside WB.
REQ-023 Latency with zero-wait memory: 5 cycles per instruction with the MEM stage, 4 without it.

Reset
REQ-024 Reset assertion SHALL asynchronously force: state=IF_REQ, pc=RESET_PC, ir=0, mem_rdata=0, retire_cnt=0, and all request, rf_we and retire outputs to 0.
REQ-025 Reset mid-transaction SHALL abandon any outstanding handshake; the first inst_req after deassertion appears in the first clk edge cycle after release.

Configuration
REQ-026 Macro MC_SEQ_SKIP_MEM_EN defined: EXE goes to WB when dec_is_load and dec_is_store are both 0; otherwise it goes to MEM_REQ.
REQ-027 Macro MC_SEQ_SKIP_MEM_EN undefined: every instruction passes through MEM_REQ. For a non-memory instruction, MEM_REQ lasts one cycle with data_req=0 (fixed 5-cycle legacy timing).

Structure
REQ-028 A shared package mc_pkg SHALL hold the state enum, the phase bit indices (PH_IF..PH_WB) and the RESET_PC default constant.
REQ-029 SHALL have one sub-module, mc_mem_hs: generic req/addr_ok/data_ok handshake tracker, instantiated once for the instruction port and once for the data port.

Verification
REQ-030 Zero-wait memory (addr_ok and data_ok same cycle as req), 3 ALU instructions -> retire pulses at cycles 5, 10, 15 (4, 8, 12 with MC_SEQ_SKIP_MEM_EN); retire_cnt=3.
REQ-031 inst_addr_ok delayed 2 cycles, data_ok 3 cycles later -> inst_addr stable at 32'h1c000000 throughout; ir=inst_rdata sampled on the data_ok cycle.
REQ-032 Load with data_rdata=32'hdeadbeef, data_data_ok 4 cycles after addr_ok -> mem_rdata=32'hdeadbeef in WB, rf_we=1; store -> data_wr=1, mem_rdata unchanged, rf_we per dec_rf_we=0.
REQ-033 next_pc=32'h1c000100 in WB -> next inst_addr=32'h1c000100; spurious data_data_ok during ID -> no state change.
REQ-034 reset asserted in IF_WAIT and in MEM_WAIT -> outputs reach reset values without a clk edge; after release, the fetch address is 32'h1c000000.
REQ-035 CNT_W=4, 17 retirements -> retire_cnt=1 (wrap-around).
